// File: rtl/div_mnbit_seq.sv
// Sequential restoring divider: M-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional self-check of quot*b + rem against a is enabled by defining DIV_CHECK_EN.
module div_mnbit_seq #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [M-1:0] quot,
  output logic [N-1:0] rem,
  output logic         div_by_zero,
  output logic         check_err
);

  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [M-1:0]  dvd;
  logic [M-1:0]  qwork;
  logic [N:0]    prem;
  logic [N-1:0]  dsr;
  logic [CW-1:0] cnt;

  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic [N:0]    prem_nx;
  logic          qbit;
  logic [M-1:0]  qwork_nx;
  logic          last;
  logic [N-1:0]  rem_dz;
  logic          chk_fail;

  // Divide-by-zero remainder is the low N bits of a, zero-extended when a is narrower.
  if (M >= N) begin : g_dz_wide
    assign rem_dz = a[N-1:0];
  end else begin : g_dz_narrow
    assign rem_dz = {{(N-M){1'b0}}, a};
  end

  always_comb begin
    shifted  = {prem[N-1:0], dvd[M-1]};
    diff     = shifted - {1'b0, dsr};
    qbit     = ~diff[N];
    prem_nx  = qbit ? diff : shifted;
    qwork_nx = {qwork[M-2:0], qbit};
    last     = (cnt == CW'(M - 1));
  end

`ifdef DIV_CHECK_EN
  logic [M-1:0]   a_hold;
  logic [M+N-1:0] recon;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_hold <= '0;
    end else if (state == IDLE && start) begin
      a_hold <= a;
    end
  end

  always_comb begin
    recon    = (M+N)'(qwork_nx) * (M+N)'(dsr) + (M+N)'(prem_nx[N-1:0]);
    chk_fail = (recon != (M+N)'(a_hold));
  end
`else
  assign chk_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (b == '0) ? DONE : RUN;
      RUN:  if (last)  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // Working registers are separate from the result registers so results hold during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd         <= '0;
      qwork       <= '0;
      prem        <= '0;
      dsr         <= '0;
      cnt         <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      check_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd   <= a;
            dsr   <= b;
            prem  <= '0;
            qwork <= '0;
            cnt   <= '0;
            if (b == '0) begin
              quot        <= '1;
              rem         <= rem_dz;
              div_by_zero <= 1'b1;
              check_err   <= 1'b0;
            end
          end
        end
        RUN: begin
          dvd   <= dvd << 1;
          prem  <= prem_nx;
          qwork <= qwork_nx;
          cnt   <= cnt + 1'b1;
          if (last) begin
            quot        <= qwork_nx;
            rem         <= prem_nx[N-1:0];
            div_by_zero <= 1'b0;
            check_err   <= chk_fail;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mnbit_seq.sv
// Directed self-checking bench for div_mnbit_seq at M=8, N=4.
module tb_div_mnbit_seq;

  localparam int M = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [M-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         done;
  logic [M-1:0] quot;
  logic [N-1:0] rem;
  logic         div_by_zero;
  logic         check_err;

  int total = 0;
  int bad   = 0;

  div_mnbit_seq #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .quot(quot), .rem(rem),
    .div_by_zero(div_by_zero), .check_err(check_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an operation for one accept edge; returns at the negedge after it.
  task automatic issue(input logic [M-1:0] av, input logic [N-1:0] bv);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n = negedges since the accept edge at which done is seen (1 = first cycle after accept).
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int errs;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    a = 8'hFF; b = 4'hF; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_cerr", check_err, 0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    // 200 / 7 = 28 r 4
    issue(8'd200, 4'd7);
    chk("busy_ready", ready, 0);
    wait_done(n);
    chk("lat_200_7", n, 9);
    chk("q_200_7", quot, 28);
    chk("r_200_7", rem, 4);
    chk("dbz_200_7", div_by_zero, 0);
    chk("cerr_200_7", check_err, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_ready", ready, 1);

    // 255 / 15 = 17 r 0
    issue(8'd255, 4'd15);
    wait_done(n);
    chk("lat_255_15", n, 9);
    chk("q_255_15", quot, 17);
    chk("r_255_15", rem, 0);
    repeat (3) @(negedge clk);
    chk("hold_q_idle", quot, 17);

    // 5 / 9 = 0 r 5; previous result must hold while running
    issue(8'd5, 4'd9);
    @(negedge clk);
    @(negedge clk);
    chk("hold_q_run", quot, 17);
    chk("hold_r_run", rem, 0);
    wait_done(n);
    chk("lat_5_9", n, 7);
    chk("q_5_9", quot, 0);
    chk("r_5_9", rem, 5);

    // divide by zero: 0xA5 / 0
    @(negedge clk);
    issue(8'hA5, 4'd0);
    wait_done(n);
    chk("lat_dz", n, 1);
    chk("q_dz", quot, 8'hFF);
    chk("r_dz", rem, 4'h5);
    chk("dbz_dz", div_by_zero, 1);
    chk("cerr_dz", check_err, 0);
    @(negedge clk);

    // 100 / 3 = 33 r 1, with start toggling (a=1, b=1) during RUN and high in DONE
    issue(8'd100, 4'd3);
    a = 8'd1; b = 4'd1;
    errs = 0;
    for (int i = 1; i <= 8; i++) begin
      if (ready !== 1'b0) errs++;
      start = ~start;
      @(negedge clk);
    end
    start = 1'b1;
    chk("run_ready_low", errs, 0);
    chk("done_100_3", done, 1);
    chk("q_100_3", quot, 33);
    chk("r_100_3", rem, 1);
    chk("dbz_100_3", div_by_zero, 0);
    start = 1'b0;
    @(negedge clk);
    chk("after_toggle_ready", ready, 1);
    @(negedge clk);
    chk("after_toggle_idle", ready, 1);

    // reset during the 4th RUN cycle
    issue(8'd200, 4'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_quot", quot, 0);
    chk("mid_rst_rem", rem, 0);
    errs = 0;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0) errs++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", errs, 0);

    // 9 / 2 = 4 r 1 with start held high across done
    a = 8'd9; b = 4'd2; start = 1'b1;
    @(negedge clk);
    wait_done(n);
    chk("lat_9_2", n, 9);
    chk("q_9_2", quot, 4);
    chk("r_9_2", rem, 1);
    @(negedge clk);
    chk("held_start_idle", ready, 1);
    @(negedge clk);
    chk("held_start_accept", ready, 0);
    start = 1'b0;
    wait_done(n);
    chk("lat_9_2b", n, 9);
    chk("q_9_2b", quot, 4);
    chk("r_9_2b", rem, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
